// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: h/v counters, active-low syncs, active-video flag,
// pixel coordinates and linear frame-buffer address, all registered and decoded from the same counts.
module vga_timing_gen #(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 144,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 34,
    parameter int unsigned V_FRONT = 11
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic        HS,
    output logic        VS,
    output logic        blank_n,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [18:0] pix_addr,
    output logic        frame_start
);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
    localparam logic [9:0] H_BEG   = 10'(H_BACK);
    localparam logic [9:0] V_BEG   = 10'(V_BACK);
    localparam logic [9:0] H_END   = 10'(H_TOTAL - H_FRONT);
    localparam logic [9:0] V_END   = 10'(V_TOTAL - V_FRONT);

    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [18:0] pix_addr_q, pix_addr_d;
    logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;
    logic        h_act, v_act;

    // Every output register is decoded from the *next* counter values, so all ports
    // describe the same raster position in any given cycle.
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
        h_act   = (h_cnt_d >= H_BEG) && (h_cnt_d < H_END);
        v_act   = (v_cnt_d >= V_BEG) && (v_cnt_d < V_END);
        blank_d = h_act && v_act;
        hs_d    = (h_cnt_d >= H_SYNC_C);
        vs_d    = (v_cnt_d >= V_SYNC_C);
        x_d     = blank_d ? h_cnt_d - H_BEG : '0;
        y_d     = blank_d ? v_cnt_d - V_BEG : '0;
        fs_d    = (h_cnt_d == '0) && (v_cnt_d == '0);
        // Address counts pixels already emitted; it holds across blanking and after the last pixel.
        pix_addr_d = fs_d ? '0 : pix_addr_q + {18'd0, blank_q};
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            blank_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            pix_addr_q <= '0;
            fs_q       <= 1'b1;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            blank_q    <= blank_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pix_addr_q <= pix_addr_d;
            fs_q       <= fs_d;
        end
    end

    assign HS          = hs_q;
    assign VS          = vs_q;
    assign blank_n     = blank_q;
    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign x           = x_q;
    assign y           = y_q;
    assign pix_addr    = pix_addr_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance plus a reduced-geometry instance for whole
// frames and random mid-frame resets, both checked against a time-index raster model.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1;
    logic chk = 1'b0, a_clean = 1'b0, b_clean = 1'b0, b_done = 1'b0;
    int   n_tests = 0, n_fail = 0;
    int   ta = 0, tb_t = 0;
    int   a_hs_low = 0, a_line_blank = 0, a_max = 0, b_blank = 0;

    logic hs_a, vs_a, bl_a, fs_a, hs_b, vs_b, bl_b, fs_b;
    logic [9:0] h_a, v_a, x_a, y_a, h_b, v_b, x_b, y_b;
    logic [18:0] pa_a, pa_b;
    logic [62:0] vec_a, vec_b;

    vga_timing_gen dut_a (
        .vga_clk(clk), .reset(rst_a), .HS(hs_a), .VS(vs_a), .blank_n(bl_a),
        .h_cnt(h_a), .v_cnt(v_a), .x(x_a), .y(y_a), .pix_addr(pa_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_TOTAL(40), .H_SYNC(4), .H_BACK(10), .H_FRONT(6),
        .V_TOTAL(30), .V_SYNC(2), .V_BACK(5), .V_FRONT(3)
    ) dut_b (
        .vga_clk(clk), .reset(rst_b), .HS(hs_b), .VS(vs_b), .blank_n(bl_b),
        .h_cnt(h_b), .v_cnt(v_b), .x(x_b), .y(y_b), .pix_addr(pa_b), .frame_start(fs_b)
    );

    assign vec_a = {hs_a, vs_a, bl_a, fs_a, h_a, v_a, x_a, y_a, pa_a};
    assign vec_b = {hs_b, vs_b, bl_b, fs_b, h_b, v_b, x_b, y_b, pa_b};

    task automatic check(input string tag, input logic [62:0] got, input logic [62:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Raster position is a pure function of clocks since reset; pix_addr counts active
    // pixels that precede the position in raster order.
    function automatic logic [62:0] expect_vec(input int t, input int ht, input int hsw, input int hb,
                                               input int hf, input int vt, input int vsw, input int vb,
                                               input int vf);
        int h, v, ha, va, pa, xx, yy;
        logic hs, vs, act, fs;
        h  = t % ht;
        v  = (t / ht) % vt;
        ha = ht - hb - hf;
        va = vt - vb - vf;
        hs = (h >= hsw);
        vs = (v >= vsw);
        act = (h >= hb) && (h < ht - hf) && (v >= vb) && (v < vt - vf);
        fs = (h == 0) && (v == 0);
        xx = act ? h - hb : 0;
        yy = act ? v - vb : 0;
        if (v < vb)             pa = 0;
        else if (v >= vb + va)  pa = va * ha;
        else if (h < hb)        pa = (v - vb) * ha;
        else if (h >= hb + ha)  pa = (v - vb + 1) * ha;
        else                    pa = (v - vb) * ha + (h - hb);
        return {hs, vs, act, fs, 10'(h), 10'(v), 10'(xx), 10'(yy), 19'(pa)};
    endfunction

    always @(posedge clk) begin
        ta   <= rst_a ? 0 : ta + 1;
        tb_t <= rst_b ? 0 : tb_t + 1;
    end

    always @(negedge clk) begin
        if (chk) begin
            check("A_raster", vec_a, expect_vec(ta, 800, 96, 144, 16, 525, 2, 34, 11));
            check("B_raster", vec_b, expect_vec(tb_t, 40, 4, 10, 6, 30, 2, 5, 3));
            if (a_clean) begin
                if (ta < 800 && !hs_a) a_hs_low++;
                if (ta == 800) check("A_hs_low_width", 63'(a_hs_low), 63'(96));
                if (v_a == 10'd34 && bl_a) begin
                    a_line_blank++;
                    if (int'(pa_a) > a_max) a_max = int'(pa_a);
                end
                if (ta == 35 * 800) begin
                    check("A_line34_active", 63'(a_line_blank), 63'(640));
                    check("A_line34_addr_max", 63'(a_max), 63'(639));
                end
            end
            if (b_clean) begin
                if (tb_t < 1200 && bl_b) b_blank++;
                if (tb_t == 1200) check("B_frame_active", 63'(b_blank), 63'(528));
            end
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        b_clean = 1'b1;
        repeat (2500) @(posedge clk);
        #1;
        b_clean = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(1, 1500)) @(posedge clk);
            #1 rst_b = 1'b1;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1 rst_b = 1'b0;
        end
        b_done = 1'b1;
    end

    initial begin
        repeat (6) @(posedge clk);
        #1;
        rst_a = 1'b0;
        a_clean = 1'b1;
        repeat (36 * 800) @(posedge clk);
        #1;
        a_clean = 1'b0;
        repeat ($urandom_range(1, 400)) @(posedge clk);
        #1 rst_a = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 rst_a = 1'b0;
        repeat (900) @(posedge clk);
        @(negedge clk);
        check("B_stimulus_done", 63'(b_done), 63'(1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
